// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Owns the single data port of the 16384 x 32 BlockRAM and shares it between
// requester A (CPU data path) and requester B (DMA / peripheral master).
// Reads and full-word writes issue in one cycle. Partial-byte writes take two
// cycles: a read of the target word, then the write. The memory merges the
// unselected bytes from its registered read data, so it needs that first read.
// The grant pulse and the memory command are combinational in the issuing
// cycle. Between issues the address, data and byte enables hold their last
// driven values.

module mem_port_arbiter #(
   parameter int AW = 14,
   parameter int DW = 32,
   parameter int RR = 1
) (
   input  logic               clk_125mhz,
   input  logic               reset,
   input  logic               a_req,
   input  logic               a_we,
   input  logic [AW-1:0]      a_addr,
   input  logic [DW-1:0]      a_wdata,
   input  logic [DW/8-1:0]    a_be,
   output logic               a_gnt,
   output logic               a_rvalid,
   input  logic               b_req,
   input  logic               b_we,
   input  logic [AW-1:0]      b_addr,
   input  logic [DW-1:0]      b_wdata,
   input  logic [DW/8-1:0]    b_be,
   output logic               b_gnt,
   output logic               b_rvalid,
   output logic [DW-1:0]      rdata,
   output logic               mem_we,
   output logic [AW-1:0]      mem_addr,
   output logic [DW-1:0]      mem_wdata,
   output logic [DW/8-1:0]    mem_be,
   input  logic [DW-1:0]      mem_rdata
);

   localparam int   BW    = DW / 8;
   localparam logic RR_EN = (RR != 32'sd0);

   typedef enum logic [0:0] {
      IDLE   = 1'b0,
      WMERGE = 1'b1
   } state_t;

   // Every byte lane is enabled, so the write needs no merge.
   function automatic logic be_full(input logic [BW-1:0] be);
      return &be;
   endfunction

   // No byte lane is enabled, so the write has no memory effect.
   function automatic logic be_none(input logic [BW-1:0] be);
      return ~(|be);
   endfunction

   state_t          state_r;
   logic            last_b_r;     // 1: B was granted last (the reset value)
   logic            wm_b_r;       // owner of the merge in progress
   logic            a_rvalid_r;
   logic            b_rvalid_r;
   logic [AW-1:0]   addr_r;
   logic [DW-1:0]   wdata_r;
   logic [BW-1:0]   be_r;

   state_t          next_state_s;
   logic            pick_b_s;
   logic            owner_b_s;
   logic            sel_req_s;
   logic            sel_we_s;
   logic [AW-1:0]   sel_addr_s;
   logic [DW-1:0]   sel_wdata_s;
   logic [BW-1:0]   sel_be_s;
   logic            gnt_s;
   logic            issue_s;
   logic            mem_we_s;

   // Choose the winner, select its fields and decode this cycle's command.
   always_comb begin
      gnt_s        = 1'b0;
      issue_s      = 1'b0;
      mem_we_s     = 1'b0;
      next_state_s = IDLE;
      pick_b_s     = 1'b0;

      if (a_req && b_req) begin
         pick_b_s = RR_EN ? ~last_b_r : 1'b0;
      end else if (b_req) begin
         pick_b_s = 1'b1;
      end else begin
         pick_b_s = 1'b0;
      end

      if (state_r == WMERGE) begin
         owner_b_s = wm_b_r;
      end else begin
         owner_b_s = pick_b_s;
      end

      if (owner_b_s) begin
         sel_req_s   = b_req;
         sel_we_s    = b_we;
         sel_addr_s  = b_addr;
         sel_wdata_s = b_wdata;
         sel_be_s    = b_be;
      end else begin
         sel_req_s   = a_req;
         sel_we_s    = a_we;
         sel_addr_s  = a_addr;
         sel_wdata_s = a_wdata;
         sel_be_s    = a_be;
      end

      if (reset) begin
         gnt_s        = 1'b0;
         issue_s      = 1'b0;
         mem_we_s     = 1'b0;
         next_state_s = IDLE;
      end else begin
         case (state_r)
            IDLE: begin
               if (sel_req_s) begin
                  issue_s = 1'b1;
                  if (sel_we_s && !be_full(sel_be_s) && !be_none(sel_be_s)) begin
                     next_state_s = WMERGE;
                  end else begin
                     gnt_s    = 1'b1;
                     mem_we_s = sel_we_s & be_full(sel_be_s);
                  end
               end else begin
                  next_state_s = IDLE;
               end
            end
            WMERGE: begin
               if (sel_req_s) begin
                  issue_s  = 1'b1;
                  gnt_s    = 1'b1;
                  mem_we_s = 1'b1;
               end else begin
                  next_state_s = IDLE;
               end
            end
            default: begin
               next_state_s = IDLE;
            end
         endcase
      end
   end

   // State, arbitration pointer, read-valid pipeline and command shadow.
   always_ff @(posedge clk_125mhz or posedge reset) begin
      if (reset) begin
         state_r    <= IDLE;
         last_b_r   <= 1'b1;
         wm_b_r     <= 1'b0;
         a_rvalid_r <= 1'b0;
         b_rvalid_r <= 1'b0;
         addr_r     <= {AW{1'b0}};
         wdata_r    <= {DW{1'b0}};
         be_r       <= {BW{1'b0}};
      end else begin
         state_r <= next_state_s;
         if ((state_r == IDLE) && (next_state_s == WMERGE)) begin
            wm_b_r <= owner_b_s;
         end
         if (gnt_s) begin
            last_b_r <= owner_b_s;
         end
         a_rvalid_r <= gnt_s & ~owner_b_s & ~sel_we_s;
         b_rvalid_r <= gnt_s &  owner_b_s & ~sel_we_s;
         if (issue_s) begin
            addr_r  <= sel_addr_s;
            wdata_r <= sel_wdata_s;
            be_r    <= sel_be_s;
         end
      end
   end

   assign a_gnt     = gnt_s & ~owner_b_s;
   assign b_gnt     = gnt_s &  owner_b_s;
   assign a_rvalid  = a_rvalid_r;
   assign b_rvalid  = b_rvalid_r;
   assign rdata     = mem_rdata;
   assign mem_we    = mem_we_s;
   assign mem_addr  = issue_s ? sel_addr_s  : addr_r;
   assign mem_wdata = issue_s ? sel_wdata_s : wdata_r;
   assign mem_be    = issue_s ? sel_be_s    : be_r;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. It holds a behavioural 16384 x 32 memory
// with a registered read port that merges unselected bytes from that read
// register. A second instance with fixed priority (RR=0) gets the same stimulus.

module tb_mem_port_arbiter;

   logic         clk_125mhz = 1'b0;
   logic         reset;
   logic         a_req, a_we, b_req, b_we;
   logic [13:0]  a_addr, b_addr;
   logic [31:0]  a_wdata, b_wdata;
   logic [3:0]   a_be, b_be;
   logic         a_gnt, a_rvalid, b_gnt, b_rvalid;
   logic [31:0]  rdata;
   logic         mem_we;
   logic [13:0]  mem_addr;
   logic [31:0]  mem_wdata;
   logic [3:0]   mem_be;
   logic [31:0]  mem_rdata;

   logic         fp_a_gnt, fp_a_rvalid, fp_b_gnt, fp_b_rvalid;
   logic [31:0]  fp_rdata;
   logic         fp_mem_we;
   logic [13:0]  fp_mem_addr;
   logic [31:0]  fp_mem_wdata;
   logic [3:0]   fp_mem_be;
   logic [31:0]  fp_mem_rdata;

   logic         bd_we;
   logic [13:0]  bd_addr;
   logic [31:0]  bd_data;
   logic [31:0]  mem [0:16383];

   int n_checks = 0;
   int n_fail   = 0;

   assign fp_mem_rdata = 32'h0000_0000;

   always #4 clk_125mhz = ~clk_125mhz;

   mem_port_arbiter #(.AW(14), .DW(32), .RR(1)) dut (
      .clk_125mhz(clk_125mhz), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_gnt(a_gnt), .a_rvalid(a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_gnt(b_gnt), .b_rvalid(b_rvalid),
      .rdata(rdata), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_be(mem_be), .mem_rdata(mem_rdata)
   );

   mem_port_arbiter #(.AW(14), .DW(32), .RR(0)) dut_fp (
      .clk_125mhz(clk_125mhz), .reset(reset),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_be(a_be),
      .a_gnt(fp_a_gnt), .a_rvalid(fp_a_rvalid),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_be(b_be),
      .b_gnt(fp_b_gnt), .b_rvalid(fp_b_rvalid),
      .rdata(fp_rdata), .mem_we(fp_mem_we), .mem_addr(fp_mem_addr), .mem_wdata(fp_mem_wdata),
      .mem_be(fp_mem_be), .mem_rdata(fp_mem_rdata)
   );

   function automatic logic [31:0] merge(input logic [31:0] wd, input logic [3:0] be,
                                         input logic [31:0] old);
      logic [31:0] r;
      for (int i = 0; i < 4; i++) begin
         r[8*i +: 8] = be[i] ? wd[8*i +: 8] : old[8*i +: 8];
      end
      return r;
   endfunction

   // Behavioural BlockRAM: registered read, merged write, backdoor preload.
   always @(posedge clk_125mhz) begin
      mem_rdata <= mem[mem_addr];
      if (bd_we) begin
         mem[bd_addr] <= bd_data;
      end else if (mem_we) begin
         mem[mem_addr] <= merge(mem_wdata, mem_be, mem_rdata);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge, then let inputs settle.
   task automatic tick();
      @(posedge clk_125mhz);
      #1;
   endtask

   task automatic preload(input logic [13:0] addr, input logic [31:0] data);
      bd_we   = 1'b1;
      bd_addr = addr;
      bd_data = data;
      tick();
      bd_we   = 1'b0;
   endtask

   task automatic idle_inputs();
      a_req = 1'b0; a_we = 1'b0; a_addr = 14'h0; a_wdata = 32'h0; a_be = 4'h0;
      b_req = 1'b0; b_we = 1'b0; b_addr = 14'h0; b_wdata = 32'h0; b_be = 4'h0;
   endtask

   initial begin
      reset = 1'b1;
      bd_we = 1'b0; bd_addr = 14'h0; bd_data = 32'h0;
      idle_inputs();
      preload(14'h0010, 32'hDEAD_BEEF);
      preload(14'h0030, 32'hAABB_CCDD);
      preload(14'h0040, 32'h5566_7788);
      preload(14'h0050, 32'h1234_5678);
      preload(14'h3FFF, 32'hCAFE_F00D);
      preload(14'h0000, 32'h0102_0304);

      // Reset state, with a request present that must not be granted.
      a_req = 1'b1;
      #2;
      chk("rst_a_gnt",    {31'h0, a_gnt},    32'h0);
      chk("rst_b_gnt",    {31'h0, b_gnt},    32'h0);
      chk("rst_a_rvalid", {31'h0, a_rvalid}, 32'h0);
      chk("rst_b_rvalid", {31'h0, b_rvalid}, 32'h0);
      chk("rst_mem_we",   {31'h0, mem_we},   32'h0);
      chk("rst_mem_addr", {18'h0, mem_addr}, 32'h0);
      chk("rst_mem_wdata", mem_wdata,        32'h0);
      chk("rst_mem_be",   {28'h0, mem_be},   32'h0);
      tick();
      reset = 1'b0;
      a_req = 1'b0;
      tick();

      // Single A read of 0x0010.
      a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
      #2;
      chk("rd_a_gnt",    {31'h0, a_gnt},    32'h1);
      chk("rd_b_gnt",    {31'h0, b_gnt},    32'h0);
      chk("rd_mem_we",   {31'h0, mem_we},   32'h0);
      chk("rd_mem_addr", {18'h0, mem_addr}, 32'h0010);
      tick();
      a_req = 1'b0;
      #2;
      chk("rd_a_rvalid", {31'h0, a_rvalid}, 32'h1);
      chk("rd_rdata",    rdata,             32'hDEAD_BEEF);
      chk("rd_b_rvalid", {31'h0, b_rvalid}, 32'h0);
      chk("rd_a_gnt_off", {31'h0, a_gnt},   32'h0);
      chk("rd_addr_hold", {18'h0, mem_addr}, 32'h0010);
      tick();

      // Fresh reset so A wins the first tie, then both read continuously.
      reset = 1'b1;
      tick();
      reset = 1'b0;
      a_req = 1'b1; a_we = 1'b0; a_addr = 14'h0010;
      b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0030;
      #2;
      chk("rr0_a_gnt",  {31'h0, a_gnt},     32'h1);
      chk("rr0_b_gnt",  {31'h0, b_gnt},     32'h0);
      chk("rr0_addr",   {18'h0, mem_addr},  32'h0010);
      chk("fp0_a_gnt",  {31'h0, fp_a_gnt},  32'h1);
      tick();
      #2;
      chk("rr1_a_gnt",  {31'h0, a_gnt},     32'h0);
      chk("rr1_b_gnt",  {31'h0, b_gnt},     32'h1);
      chk("rr1_addr",   {18'h0, mem_addr},  32'h0030);
      chk("rr1_a_rv",   {31'h0, a_rvalid},  32'h1);
      chk("rr1_rdata",  rdata,              32'hDEAD_BEEF);
      chk("fp1_a_gnt",  {31'h0, fp_a_gnt},  32'h1);
      chk("fp1_b_gnt",  {31'h0, fp_b_gnt},  32'h0);
      tick();
      #2;
      chk("rr2_a_gnt",  {31'h0, a_gnt},     32'h1);
      chk("rr2_b_rv",   {31'h0, b_rvalid},  32'h1);
      chk("rr2_rdata",  rdata,              32'hAABB_CCDD);
      chk("fp2_a_gnt",  {31'h0, fp_a_gnt},  32'h1);
      tick();
      #2;
      chk("rr3_b_gnt",  {31'h0, b_gnt},     32'h1);
      chk("rr3_a_rv",   {31'h0, a_rvalid},  32'h1);
      chk("fp3_b_gnt",  {31'h0, fp_b_gnt},  32'h0);
      tick();
      idle_inputs();
      #2;
      chk("rr4_b_rv",   {31'h0, b_rvalid},  32'h1);
      chk("rr4_a_rv",   {31'h0, a_rvalid},  32'h0);
      tick();

      // A full-word write to 0x0020, then read back.
      a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0020; a_wdata = 32'h1122_3344; a_be = 4'hF;
      #2;
      chk("fw_a_gnt",  {31'h0, a_gnt},    32'h1);
      chk("fw_mem_we", {31'h0, mem_we},   32'h1);
      chk("fw_addr",   {18'h0, mem_addr}, 32'h0020);
      chk("fw_wdata",  mem_wdata,         32'h1122_3344);
      chk("fw_be",     {28'h0, mem_be},   32'hF);
      tick();
      a_we = 1'b0;
      #2;
      chk("fw_no_rv",  {31'h0, a_rvalid}, 32'h0);
      chk("fwr_gnt",   {31'h0, a_gnt},    32'h1);
      chk("fwr_we",    {31'h0, mem_we},   32'h0);
      tick();
      idle_inputs();
      #2;
      chk("fwr_rv",    {31'h0, a_rvalid}, 32'h1);
      chk("fwr_rdata", rdata,             32'h1122_3344);
      tick();

      // B partial write of byte 0 at 0x0030.
      b_req = 1'b1; b_we = 1'b1; b_addr = 14'h0030; b_wdata = 32'h0000_00EE; b_be = 4'h1;
      #2;
      chk("pw1_b_gnt", {31'h0, b_gnt},    32'h0);
      chk("pw1_we",    {31'h0, mem_we},   32'h0);
      chk("pw1_addr",  {18'h0, mem_addr}, 32'h0030);
      tick();
      #2;
      chk("pw2_b_gnt", {31'h0, b_gnt},    32'h1);
      chk("pw2_a_gnt", {31'h0, a_gnt},    32'h0);
      chk("pw2_we",    {31'h0, mem_we},   32'h1);
      chk("pw2_be",    {28'h0, mem_be},   32'h1);
      chk("pw2_addr",  {18'h0, mem_addr}, 32'h0030);
      tick();
      b_we = 1'b0;
      #2;
      chk("pwr_gnt",   {31'h0, b_gnt},    32'h1);
      chk("pw_no_rv",  {31'h0, b_rvalid}, 32'h0);
      tick();
      idle_inputs();
      #2;
      chk("pwr_rv",    {31'h0, b_rvalid}, 32'h1);
      chk("pwr_rdata", rdata,             32'hAABB_CCEE);
      tick();

      // Reset asserted during the merge cycle abandons the write.
      a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0050; a_wdata = 32'hFFFF_FFFF; a_be = 4'h3;
      #2;
      chk("rm1_we",    {31'h0, mem_we},   32'h0);
      tick();
      reset = 1'b1;
      #2;
      chk("rm2_we",    {31'h0, mem_we},   32'h0);
      chk("rm2_a_gnt", {31'h0, a_gnt},    32'h0);
      chk("rm2_b_gnt", {31'h0, b_gnt},    32'h0);
      chk("rm2_a_rv",  {31'h0, a_rvalid}, 32'h0);
      chk("rm2_addr",  {18'h0, mem_addr}, 32'h0);
      tick();
      reset = 1'b0;
      idle_inputs();
      tick();
      chk("rm_word",   mem[14'h0050],     32'h1234_5678);

      // A partial write withdrawn during the merge cycle, while B is waiting.
      a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0060; a_wdata = 32'hFFFF_FFFF; a_be = 4'h2;
      tick();
      a_req = 1'b0;
      b_req = 1'b1; b_we = 1'b0; b_addr = 14'h0010;
      #2;
      chk("wd_we",     {31'h0, mem_we},   32'h0);
      chk("wd_a_gnt",  {31'h0, a_gnt},    32'h0);
      chk("wd_b_gnt",  {31'h0, b_gnt},    32'h0);
      tick();
      #2;
      chk("wd_b_next", {31'h0, b_gnt},    32'h1);
      tick();
      idle_inputs();
      #2;
      chk("wd_rdata",  rdata,             32'hDEAD_BEEF);
      tick();

      // Zero byte-enable write: granted, no memory effect.
      a_req = 1'b1; a_we = 1'b1; a_addr = 14'h0040; a_wdata = 32'hFFFF_FFFF; a_be = 4'h0;
      #2;
      chk("z_a_gnt",   {31'h0, a_gnt},    32'h1);
      chk("z_we",      {31'h0, mem_we},   32'h0);
      tick();
      a_we = 1'b0;
      tick();
      idle_inputs();
      #2;
      chk("z_rdata",   rdata,             32'h5566_7788);
      tick();

      // Top address followed by address zero, back to back.
      a_req = 1'b1; a_we = 1'b0; a_addr = 14'h3FFF;
      #2;
      chk("top_gnt",   {31'h0, a_gnt},    32'h1);
      chk("top_addr",  {18'h0, mem_addr}, 32'h3FFF);
      tick();
      a_addr = 14'h0000;
      #2;
      chk("top_rdata", rdata,             32'hCAFE_F00D);
      chk("zero_gnt",  {31'h0, a_gnt},    32'h1);
      chk("zero_addr", {18'h0, mem_addr}, 32'h0);
      tick();
      idle_inputs();
      #2;
      chk("zero_rv",   {31'h0, a_rvalid}, 32'h1);
      chk("zero_rdata", rdata,            32'h0102_0304);
      tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
